// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-search datapath: widths and the
// ciphertext loader state encoding.
package arc4_pkg;

    localparam int KEY_W  = 24;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_ERR_DRAIN = 3'd4
    } ct_loader_state_t;

endpackage

// File: rtl/ct_loader.sv
// Ciphertext loader: takes a length-prefixed byte stream from the host,
// writes it into CT RAM (length at address 0, payload at 1..L), then
// starts crack and latches the key it reports.
//
//  state      | meaning
//  -----------+------------------------------------------------------
//  IDLE       | waiting for the length byte of a new message
//  LOAD       | accepting payload bytes 1..L into CT RAM
//  START      | single-cycle crack_en pulse after the last RAM write
//  WAIT       | host stalled until crack_rdy, then latch key/key_valid
//  ERR_DRAIN  | discarding the remainder of a bad message up to in_last
module ct_loader
    import arc4_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [BYTE_W-1:0]    ct_addr,
    output logic [BYTE_W-1:0]    ct_wrdata,
    output logic                 ct_wren,
    output logic                 crack_en,
    input  logic                 crack_rdy,
    input  logic [KEY_W-1:0]     crack_key,
    input  logic                 crack_kvalid,
    output logic                 done,
    output logic [KEY_W-1:0]     key,
    output logic                 key_valid,
    output logic                 err
);

    // One bit wider than a byte so that MAX_LEN=255 still compares cleanly.
    localparam logic [BYTE_W:0] MAX_LEN_W = (BYTE_W+1)'(MAX_LEN);

    ct_loader_state_t  state;
    logic [BYTE_W-1:0] len;
    logic [BYTE_W-1:0] cnt;
    logic              accept;
    logic [BYTE_W-1:0] cnt_inc;
    logic              len_too_big;
    logic              at_last_byte;

    // Handshake and payload position helpers shared by the state machine.
    always_comb begin
        accept       = in_valid & in_ready;
        cnt_inc      = cnt + 8'd1;
        len_too_big  = {1'b0, in_data} > MAX_LEN_W;
        at_last_byte = (cnt_inc == len);
    end

    // Loader state machine; every output is a register so the RAM port and
    // crack_en see clean, glitch-free strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            ct_addr   <= '0;
            ct_wrdata <= '0;
            ct_wren   <= 1'b0;
            crack_en  <= 1'b0;
            done      <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            ct_wren  <= 1'b0;
            crack_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                        cnt  <= '0;
                        if (len_too_big) begin
                            // Oversized length is never written; drain the rest.
                            err <= 1'b1;
                            if (!in_last) begin
                                state <= ST_ERR_DRAIN;
                            end
                        end else begin
                            ct_wren   <= 1'b1;
                            ct_addr   <= '0;
                            ct_wrdata <= in_data;
                            len       <= in_data;
                            if (in_data == '0) begin
                                if (in_last) begin
                                    state    <= ST_START;
                                    in_ready <= 1'b0;
                                end else begin
                                    err   <= 1'b1;
                                    state <= ST_ERR_DRAIN;
                                end
                            end else if (in_last) begin
                                // Length promised payload but message ended.
                                err <= 1'b1;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                end

                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        ct_wren   <= 1'b1;
                        ct_addr   <= cnt_inc;
                        ct_wrdata <= in_data;
                        cnt       <= cnt_inc;
                        if (at_last_byte) begin
                            if (in_last) begin
                                state    <= ST_START;
                                in_ready <= 1'b0;
                            end else begin
                                // Message runs past L; swallow the excess.
                                err   <= 1'b1;
                                state <= ST_ERR_DRAIN;
                            end
                        end else if (in_last) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_ERR_DRAIN: begin
                    in_ready <= 1'b1;
                    if (accept && in_last) begin
                        state <= ST_IDLE;
                    end
                end

                ST_START: begin
                    // The final ct_wren was the previous cycle, so RAM is complete.
                    in_ready <= 1'b0;
                    crack_en <= 1'b1;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    in_ready <= 1'b0;
                    if (crack_rdy) begin
                        key       <= crack_key;
                        key_valid <= crack_kvalid;
                        done      <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    in_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// Bench for ct_loader: message-level reference model checked every cycle,
// scripted scenarios with literal expectations, then randomized traffic.
module tb_ct_loader;
    import arc4_pkg::*;

    localparam int TB_MAX = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic        crack_en;
    logic        crack_rdy = 1'b0;
    logic [23:0] crack_key = 24'h0;
    logic        crack_kvalid = 1'b0;
    logic        done;
    logic [23:0] key;
    logic        key_valid;
    logic        err;

    ct_loader #(.MAX_LEN(TB_MAX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .crack_en(crack_en), .crack_rdy(crack_rdy), .crack_key(crack_key),
        .crack_kvalid(crack_kvalid),
        .done(done), .key(key), .key_valid(key_valid), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (message parser) ----------------
    localparam int M_LEN = 0, M_PAY = 1, M_DRAIN = 2, M_GO = 3, M_WAIT = 4;
    int          m_mode = M_LEN;
    int          m_need = 0;
    int          m_got  = 0;
    bit          e_ready = 0, e_wren = 0, e_cen = 0, e_done = 0, e_err = 0, e_kv = 0;
    logic [7:0]  e_addr = 0, e_data = 0;
    logic [23:0] e_key = 0;

    int          wr_cnt = 0;
    int          cen_cnt = 0;
    logic [7:0]  last_addr = 0, last_data = 0;

    initial begin
        forever begin
            bit hs;
            @(posedge clk);
            if (rst) begin
                m_mode = M_LEN; e_ready = 0; e_wren = 0; e_cen = 0; e_done = 0;
                e_err = 0; e_kv = 0; e_addr = 0; e_data = 0; e_key = 0;
            end else begin
                hs = in_valid && e_ready;
                e_wren = 0;
                e_cen  = 0;
                case (m_mode)
                    M_LEN: if (hs) begin
                        e_done = 0;
                        e_err  = 0;
                        if (in_data > TB_MAX) begin
                            e_err = 1;
                            if (!in_last) m_mode = M_DRAIN;
                        end else begin
                            e_wren = 1; e_addr = 8'h00; e_data = in_data;
                            if (in_data == 0) begin
                                if (in_last) m_mode = M_GO;
                                else begin e_err = 1; m_mode = M_DRAIN; end
                            end else if (in_last) begin
                                e_err = 1;
                            end else begin
                                m_need = int'(in_data); m_got = 0; m_mode = M_PAY;
                            end
                        end
                    end
                    M_PAY: if (hs) begin
                        m_got++;
                        e_wren = 1; e_addr = m_got[7:0]; e_data = in_data;
                        if (m_got == m_need) begin
                            if (in_last) m_mode = M_GO;
                            else begin e_err = 1; m_mode = M_DRAIN; end
                        end else if (in_last) begin
                            e_err = 1; m_mode = M_LEN;
                        end
                    end
                    M_DRAIN: if (hs && in_last) m_mode = M_LEN;
                    M_GO: begin e_cen = 1; m_mode = M_WAIT; end
                    M_WAIT: if (crack_rdy) begin
                        e_key = crack_key; e_kv = crack_kvalid; e_done = 1; m_mode = M_LEN;
                    end
                    default: m_mode = M_LEN;
                endcase
                e_ready = (m_mode == M_LEN) || (m_mode == M_PAY) || (m_mode == M_DRAIN);
            end
            #1;
            check("in_ready",  32'(in_ready),  32'(e_ready));
            check("ct_wren",   32'(ct_wren),   32'(e_wren));
            check("ct_addr",   32'(ct_addr),   32'(e_addr));
            check("ct_wrdata", 32'(ct_wrdata), 32'(e_data));
            check("crack_en",  32'(crack_en),  32'(e_cen));
            check("done",      32'(done),      32'(e_done));
            check("err",       32'(err),       32'(e_err));
            check("key",       32'(key),       32'(e_key));
            check("key_valid", 32'(key_valid), 32'(e_kv));
            if (ct_wren === 1'b1) begin
                wr_cnt++; last_addr = ct_addr; last_data = ct_wrdata;
            end
            if (crack_en === 1'b1) cen_cnt++;
        end
    end

    // ---------------- crack engine stand-in ----------------
    logic [23:0] cfg_key = 24'h0;
    bit          cfg_kv = 0;
    int          crack_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (crack_en === 1'b1) begin
                crack_rdy = 1'b0;
                crack_cnt = $urandom_range(1, 8);
            end else if (crack_cnt > 0) begin
                crack_cnt--;
                if (crack_cnt == 0) begin
                    crack_rdy = 1'b1; crack_key = cfg_key; crack_kvalid = cfg_kv;
                end
            end else if (!crack_rdy) begin
                crack_key = 24'($urandom); crack_kvalid = 1'($urandom);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit         gaps = 0;
    logic [7:0] q_d[$];
    bit         q_l[$];

    task automatic push(input logic [7:0] d, input bit l);
        q_d.push_back(d);
        q_l.push_back(l);
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        int guard = 0;
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 0; in_data = 8'($urandom); in_last = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1; in_data = d; in_last = l;
        while (in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high t=%0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic flush();
        foreach (q_d[i]) send(q_d[i], q_l[i]);
        q_d.delete();
        q_l.delete();
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge clk);
        while (done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_bad++;
            $display("FAIL wait_done actual=done_low required=done_high t=%0t", $time);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; cen_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        // 1: reset held three cycles
        #1 rst = 1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_outputs", {ct_addr, ct_wrdata, 5'(0), ct_wren, crack_en, done, err, key_valid}, 0);
        check("rst_key", 32'(key), 0);
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 1);

        // 2: normal 53-byte payload
        clear_counts();
        cfg_key = 24'h00001F; cfg_kv = 1;
        push(8'h35, 0); push(8'h56, 0); push(8'hC1, 0); push(8'hD4, 0);
        for (int i = 0; i < 49; i++) push(8'(i * 37 + 11), 0);
        push(8'h91, 1);
        flush();
        wait_done();
        check("norm_writes", 32'(wr_cnt), 54);
        check("norm_last_addr", 32'(last_addr), 53);
        check("norm_last_data", 32'(last_data), 32'h91);
        check("norm_crack_en", 32'(cen_cnt), 1);
        check("norm_key", 32'(key), 32'h00001F);
        check("norm_key_valid", 32'(key_valid), 1);

        // 3: short message, then a good one clears err
        clear_counts();
        push(8'd4, 0); push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 1);
        flush();
        @(negedge clk);
        check("short_err", 32'(err), 1);
        check("short_ready", 32'(in_ready), 1);
        check("short_crack_en", 32'(cen_cnt), 0);
        cfg_key = 24'hABCDEF; cfg_kv = 1;
        push(8'd1, 0); push(8'h77, 1);
        flush();
        wait_done();
        check("short_err_cleared", 32'(err), 0);
        check("short_recover_key", 32'(key), 32'hABCDEF);

        // 4: long message
        clear_counts();
        push(8'd2, 0); push(8'hB1, 0); push(8'hB2, 0); push(8'hB3, 1);
        flush();
        repeat (3) @(negedge clk);
        check("long_writes", 32'(wr_cnt), 3);
        check("long_last_data", 32'(last_data), 32'hB2);
        check("long_err", 32'(err), 1);
        check("long_crack_en", 32'(cen_cnt), 0);

        // 5: back-to-back messages push into START/WAIT; kvalid=0 result
        cfg_key = 24'h123456; cfg_kv = 0;
        push(8'd1, 0); push(8'h10, 1);
        push(8'd1, 0); push(8'h20, 1);
        flush();
        wait_done();
        check("bp_key_valid", 32'(key_valid), 0);
        check("bp_key", 32'(key), 32'h123456);

        // over-length byte: no write, err, drain to in_last
        clear_counts();
        push(8'd250, 0); push(8'h01, 0); push(8'h02, 1);
        flush();
        @(negedge clk);
        check("ovl_writes", 32'(wr_cnt), 0);
        check("ovl_err", 32'(err), 1);

        // 6: reset mid-LOAD after 10 payload bytes
        push(8'd20, 0);
        for (int i = 0; i < 10; i++) push(8'(i + 1), 0);
        flush();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_outputs", {ct_addr, ct_wrdata, 5'(0), ct_wren, crack_en, done, err, key_valid}, 0);
        @(negedge clk);
        rst = 0;
        clear_counts();
        cfg_key = 24'h000042; cfg_kv = 1;
        push(8'h00, 1);
        flush();
        wait_done();
        check("zero_writes", 32'(wr_cnt), 1);
        check("zero_addr", 32'(last_addr), 0);
        check("zero_data", 32'(last_data), 0);
        check("zero_crack_en", 32'(cen_cnt), 1);

        // randomized traffic against the model
        gaps = 1;
        for (int m = 0; m < 60; m++) begin
            int kind, L, n;
            kind = $urandom_range(0, 5);
            cfg_key = 24'($urandom); cfg_kv = 1'($urandom);
            case (kind)
                0: begin
                    L = $urandom_range(0, 40);
                    push(8'(L), L == 0);
                    for (int i = 1; i <= L; i++) push(8'($urandom), i == L);
                end
                1: begin
                    L = $urandom_range(2, 20); n = $urandom_range(1, L - 1);
                    push(8'(L), 0);
                    for (int i = 1; i <= n; i++) push(8'($urandom), i == n);
                end
                2: begin
                    L = $urandom_range(1, 15); n = L + $urandom_range(1, 4);
                    push(8'(L), 0);
                    for (int i = 1; i <= n; i++) push(8'($urandom), i == n);
                end
                3: begin
                    L = $urandom_range(TB_MAX + 1, 255); n = $urandom_range(0, 3);
                    push(8'(L), n == 0);
                    for (int i = 1; i <= n; i++) push(8'($urandom), i == n);
                end
                4: push(8'($urandom_range(1, TB_MAX)), 1);
                default: begin
                    n = $urandom_range(1, 3);
                    push(8'h00, 0);
                    for (int i = 1; i <= n; i++) push(8'($urandom), i == n);
                end
            endcase
            flush();
        end
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
